// File: rtl/ibex_fp_wb_pkg.sv
// Purpose: shared types and constants for the FP register-file writeback slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: FpDataWidth (FP register width), FpNumRegs (FP register count),
// fp_wb_req_t (one register-file write request), reg_onehot() (address to bit mask).
package ibex_fp_wb_pkg;

    localparam int unsigned FpDataWidth = 16;
    localparam int unsigned FpNumRegs   = 32;

    typedef struct packed {
        logic [4:0]             waddr;
        logic [FpDataWidth-1:0] wdata;
    } fp_wb_req_t;

    // One-hot mask selecting register f<addr> in a scoreboard vector.
    function automatic logic [FpNumRegs-1:0] reg_onehot(input logic [4:0] addr);
        return FpNumRegs'(1) << addr;
    endfunction

endpackage

// File: rtl/ibex_fp_wb_fifo.sv
// Purpose: small synchronous FIFO buffering FPU results ahead of the writeback port.
// Latency: a pushed entry reaches head_o the cycle after the push (no bypass).
// Backpressure: full_o is a pure function of state; pushes while full and pops while empty are ignored.
//
// Ports: clk_i, rst_i (sync, active-high), push_i/data_i (write at tail),
// pop_i (drop head), full_o, empty_o, head_o (oldest entry, valid when !empty_o).
module ibex_fp_wb_fifo
    import ibex_fp_wb_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  fp_wb_req_t data_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output fp_wb_req_t head_o
);

    localparam int unsigned      PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned      CntW     = $clog2(Depth + 1);
    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);

    fp_wb_req_t      mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    // Fullness comes from the occupancy count, so pointers wrap without an extra bit.
    assign full_o  = (count == DepthCnt);
    assign empty_o = (count == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == LastPtr) ? '0 : wptr + PtrW'(1);
            end
            if (do_pop) begin
                rptr <= (rptr == LastPtr) ? '0 : rptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= data_i;
        end
    end

endmodule

// File: rtl/ibex_fp_wb_arbiter.sv
// Purpose: merges buffered FPU results and FP loads onto the single FP register-file write port.
// Latency: load to regfile 1 cycle; FPU to regfile at least 2 cycles (buffered, no bypass).
// Backpressure: fpu_ready_o = FIFO not full; ld_ready_o = load granted this cycle.
//
// Ports: clk_i, rst_i (sync, active-high); fpu_valid_i/fpu_ready_o/fpu_waddr_i/fpu_wdata_i;
// ld_valid_i/ld_ready_o/ld_waddr_i/ld_wdata_i; issue_valid_i/issue_waddr_i set pending_o
// (RAW scoreboard); fp_waddr_a_o/fp_wdata_a_o/fp_we_a_o drive the register-file write port.
// Optional macro IBEX_FP_WB_FWD_EN adds fwd_valid_o/fwd_waddr_o/fwd_wdata_o, a combinational
// copy of this cycle's grant for operand bypass.
module ibex_fp_wb_arbiter
    import ibex_fp_wb_pkg::*;
#(
    parameter int unsigned DataWidth   = 16,
    parameter int unsigned FifoDepth   = 2,
    parameter int unsigned StarveLimit = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fpu_valid_i,
    output logic                 fpu_ready_o,
    input  logic [4:0]           fpu_waddr_i,
    input  logic [DataWidth-1:0] fpu_wdata_i,
    input  logic                 ld_valid_i,
    output logic                 ld_ready_o,
    input  logic [4:0]           ld_waddr_i,
    input  logic [DataWidth-1:0] ld_wdata_i,
    input  logic                 issue_valid_i,
    input  logic [4:0]           issue_waddr_i,
    output logic [FpNumRegs-1:0] pending_o,
    output logic [4:0]           fp_waddr_a_o,
    output logic [DataWidth-1:0] fp_wdata_a_o,
    output logic                 fp_we_a_o
`ifdef IBEX_FP_WB_FWD_EN
    ,
    output logic                 fwd_valid_o,
    output logic [4:0]           fwd_waddr_o,
    output logic [DataWidth-1:0] fwd_wdata_o
`endif
);

    localparam int unsigned         StarveW   = $clog2(StarveLimit + 1);
    localparam logic [StarveW-1:0]  StarveMax = StarveW'(StarveLimit);

    fp_wb_req_t           fpu_req;
    fp_wb_req_t           ld_req;
    fp_wb_req_t           head_req;
    fp_wb_req_t           grant_req;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 force_fpu;
    logic                 ld_win;
    logic                 grant;
    logic                 grant_we;
    logic [StarveW-1:0]   starve_cnt;
    logic [FpNumRegs-1:0] set_mask;
    logic [FpNumRegs-1:0] clr_mask;

    assign fpu_req = '{waddr: fpu_waddr_i, wdata: fpu_wdata_i};
    assign ld_req  = '{waddr: ld_waddr_i, wdata: ld_wdata_i};

    // Ready depends only on FIFO state, never on the load side or fpu_valid_i.
    assign fpu_ready_o = !fifo_full;
    assign fifo_push   = fpu_valid_i && !fifo_full;

    ibex_fp_wb_fifo #(
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (fpu_req),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_req)
    );

    // Loads have priority, except when a full FIFO has already yielded StarveLimit times.
    assign force_fpu  = fifo_full && (starve_cnt == StarveMax);
    assign ld_win     = ld_valid_i && !force_fpu;
    assign fifo_pop   = !ld_win && !fifo_empty;
    assign grant      = ld_win || fifo_pop;
    assign ld_ready_o = ld_win;

    always_comb begin
        grant_req = head_req;
        if (ld_win) begin
            grant_req = ld_req;
        end
    end

    // f0 is hard-wired: a grant to it is consumed but never written.
    assign grant_we = grant && (grant_req.waddr != 5'd0);

    // Counts load wins only while the FPU is actually blocked by a full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (fifo_pop || !fifo_full) begin
            starve_cnt <= '0;
        end else if (ld_win) begin
            starve_cnt <= starve_cnt + StarveW'(1);
        end
    end

    // Address/data hold their last written value when nothing is written.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fp_we_a_o    <= 1'b0;
            fp_waddr_a_o <= '0;
            fp_wdata_a_o <= '0;
        end else begin
            fp_we_a_o <= grant_we;
            if (grant_we) begin
                fp_waddr_a_o <= grant_req.waddr;
                fp_wdata_a_o <= grant_req.wdata;
            end
        end
    end

    // Clear lands on the same edge that raises fp_we_a_o; a same-cycle issue re-sets the bit.
    assign set_mask = (issue_valid_i && (issue_waddr_i != 5'd0)) ? reg_onehot(issue_waddr_i) : '0;
    assign clr_mask = grant_we ? reg_onehot(grant_req.waddr) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_o <= '0;
        end else begin
            pending_o <= (pending_o & ~clr_mask) | set_mask;
        end
    end

`ifdef IBEX_FP_WB_FWD_EN
    assign fwd_valid_o = grant_we;
    assign fwd_waddr_o = grant_req.waddr;
    assign fwd_wdata_o = grant_req.wdata;
`endif

endmodule

// File: tb/tb_ibex_fp_wb_arbiter.sv
// Purpose: self-checking bench for ibex_fp_wb_arbiter, cycle-by-cycle vector table.
// Latency: each row is one clock; registered results are sampled 1ns after the edge.
// Backpressure: fpu_ready_o / ld_ready_o are compared against hand-derived expectations.
module tb_ibex_fp_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [4:0]  fpu_waddr_i;
    logic [15:0] fpu_wdata_i;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_waddr_i;
    logic [15:0] ld_wdata_i;
    logic        issue_valid_i;
    logic [4:0]  issue_waddr_i;
    logic [31:0] pending_o;
    logic [4:0]  fp_waddr_a_o;
    logic [15:0] fp_wdata_a_o;
    logic        fp_we_a_o;
`ifdef IBEX_FP_WB_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_waddr_o;
    logic [15:0] fwd_wdata_o;
`endif

    always #5 clk_i = ~clk_i;

    ibex_fp_wb_arbiter #(
        .DataWidth   (16),
        .FifoDepth   (2),
        .StarveLimit (3)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .fpu_valid_i   (fpu_valid_i),
        .fpu_ready_o   (fpu_ready_o),
        .fpu_waddr_i   (fpu_waddr_i),
        .fpu_wdata_i   (fpu_wdata_i),
        .ld_valid_i    (ld_valid_i),
        .ld_ready_o    (ld_ready_o),
        .ld_waddr_i    (ld_waddr_i),
        .ld_wdata_i    (ld_wdata_i),
        .issue_valid_i (issue_valid_i),
        .issue_waddr_i (issue_waddr_i),
        .pending_o     (pending_o),
        .fp_waddr_a_o  (fp_waddr_a_o),
        .fp_wdata_a_o  (fp_wdata_a_o),
        .fp_we_a_o     (fp_we_a_o)
`ifdef IBEX_FP_WB_FWD_EN
        ,
        .fwd_valid_o   (fwd_valid_o),
        .fwd_waddr_o   (fwd_waddr_o),
        .fwd_wdata_o   (fwd_wdata_o)
`endif
    );

    typedef struct {
        logic        rst;
        logic        fv;
        logic [4:0]  fa;
        logic [15:0] fd;
        logic        lv;
        logic [4:0]  la;
        logic [15:0] ld;
        logic        iv;
        logic [4:0]  ia;
        logic        e_ldr;   // ld_ready_o before the edge
        logic        e_fpr;   // fpu_ready_o after the edge
        logic        e_we;    // write expected from this edge
        logic [4:0]  e_wa;
        logic [15:0] e_wd;
        logic [31:0] e_pend;  // pending_o after the edge
        logic        hk;      // held address/data are known
    } vec_t;

    typedef struct {
        logic [4:0]  waddr;
        logic [15:0] wdata;
    } wr_t;

    vec_t tbl[$];
    wr_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(
        input logic rst,
        input logic fv, input logic [4:0] fa, input logic [15:0] fd,
        input logic lv, input logic [4:0] la, input logic [15:0] ld,
        input logic iv, input logic [4:0] ia,
        input logic e_ldr, input logic e_fpr,
        input logic e_we, input logic [4:0] e_wa, input logic [15:0] e_wd,
        input logic [31:0] e_pend, input logic hk);
        vec_t v;
        v.rst = rst; v.fv = fv; v.fa = fa; v.fd = fd;
        v.lv = lv; v.la = la; v.ld = ld; v.iv = iv; v.ia = ia;
        v.e_ldr = e_ldr; v.e_fpr = e_fpr; v.e_we = e_we;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_pend = e_pend; v.hk = hk;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        wr_t         w;
        logic [4:0]  last_a;
        logic [15:0] last_d;
        last_a = '0;
        last_d = '0;

        rst_i = 1'b1; fpu_valid_i = 1'b0; fpu_waddr_i = '0; fpu_wdata_i = '0;
        ld_valid_i = 1'b0; ld_waddr_i = '0; ld_wdata_i = '0;
        issue_valid_i = 1'b0; issue_waddr_i = '0;

        //            rst fv fa  fd       lv la  ld       iv ia ldr fpr we wa  wd       pend      hk
        // reset state
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,  1));
        // single FPU result f3: write appears two edges after the handshake
        tbl.push_back(mk(0, 1, 3, 16'h3C00, 0, 0, 16'h0000, 1, 3, 0, 1, 0, 0, 16'h0000, 32'h8,  1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 3, 16'h3C00, 32'h0,  1));
        // load f5 and FPU f6 together: load first, FPU next
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0, 1, 0, 0, 16'h0000, 32'h20, 1));
        tbl.push_back(mk(0, 1, 6, 16'h4000, 1, 5, 16'hBC00, 1, 6, 1, 1, 1, 5, 16'hBC00, 32'h40, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 6, 16'h4000, 32'h0,  1));
        // fill FIFO under continuous loads, then starvation limit
        tbl.push_back(mk(0, 1, 8, 16'h1111, 1, 9, 16'h2222, 0, 0, 1, 1, 1, 9, 16'h2222, 32'h0,  1));
        tbl.push_back(mk(0, 1,10, 16'h3333, 1,11, 16'h4444, 0, 0, 1, 0, 1,11, 16'h4444, 32'h0,  1));
        tbl.push_back(mk(0, 1,13, 16'h6666, 1,12, 16'h5555, 1, 4, 1, 0, 1,12, 16'h5555, 32'h10, 1));
        tbl.push_back(mk(0, 1,13, 16'h6666, 1,14, 16'h5556, 1, 5, 1, 0, 1,14, 16'h5556, 32'h30, 1));
        tbl.push_back(mk(0, 1,13, 16'h6666, 1,15, 16'h5557, 1, 6, 1, 0, 1,15, 16'h5557, 32'h70, 1));
        tbl.push_back(mk(0, 1,13, 16'h6666, 1,16, 16'h5558, 1, 7, 0, 1, 1, 8, 16'h1111, 32'hF0, 1));
        tbl.push_back(mk(0, 1,13, 16'h6666, 1,16, 16'h5558, 0, 0, 1, 0, 1,16, 16'h5558, 32'hF0, 1));
        // reset with two entries buffered and pending=0xF0
        tbl.push_back(mk(1, 1, 1, 16'h7777, 1, 2, 16'h8888, 1, 9, 0, 1, 0, 0, 16'h0000, 32'h0,  1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,  1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,  1));
        // issue f7 on the same edge a grant to f7 registers: set wins
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 7, 0, 1, 0, 0, 16'h0000, 32'h80, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 7, 16'h9999, 1, 7, 1, 1, 1, 7, 16'h9999, 32'h80, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 32'h80, 1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 7, 16'hAAAA, 0, 0, 1, 1, 1, 7, 16'hAAAA, 32'h0,  1));
        // f0: issue ignored, FPU and load grants consumed without a write
        tbl.push_back(mk(0, 1, 0, 16'hBBBB, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0, 16'h0000, 32'h0,  1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,  0));
        tbl.push_back(mk(0, 1, 2, 16'h1234, 1, 0, 16'hCCCC, 0, 0, 1, 1, 0, 0, 16'h0000, 32'h0,  0));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 1, 2, 16'h1234, 32'h0,  1));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 16'h0000, 32'h0,  1));

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            @(negedge clk_i);
            rst_i = v.rst;
            fpu_valid_i = v.fv; fpu_waddr_i = v.fa; fpu_wdata_i = v.fd;
            ld_valid_i = v.lv; ld_waddr_i = v.la; ld_wdata_i = v.ld;
            issue_valid_i = v.iv; issue_waddr_i = v.ia;
            if (v.e_we) begin
                w.waddr = v.e_wa;
                w.wdata = v.e_wd;
                sbq.push_back(w);
            end
            #1;
            if (!v.rst) chk($sformatf("row%0d ld_ready", i), 32'(ld_ready_o), 32'(v.e_ldr));

            @(posedge clk_i);
            #1;
            chk($sformatf("row%0d we", i), 32'(fp_we_a_o), 32'(v.e_we));
            chk($sformatf("row%0d pending", i), pending_o, v.e_pend);
            chk($sformatf("row%0d fpu_ready", i), 32'(fpu_ready_o), 32'(v.e_fpr));
            if (fp_we_a_o === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("row%0d unexpected_write_addr", i), 32'(fp_waddr_a_o), 32'h0);
                end else begin
                    w = sbq.pop_front();
                    chk($sformatf("row%0d waddr", i), 32'(fp_waddr_a_o), 32'(w.waddr));
                    chk($sformatf("row%0d wdata", i), 32'(fp_wdata_a_o), 32'(w.wdata));
                end
            end else if (v.e_we && sbq.size() != 0) begin
                void'(sbq.pop_front());
            end
            if (v.rst) begin
                last_a = '0;
                last_d = '0;
            end else if (v.e_we) begin
                last_a = v.e_wa;
                last_d = v.e_wd;
            end
            if (!v.e_we && v.hk) begin
                chk($sformatf("row%0d hold_addr", i), 32'(fp_waddr_a_o), 32'(last_a));
                chk($sformatf("row%0d hold_data", i), 32'(fp_wdata_a_o), 32'(last_d));
            end
        end

        chk("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ibex_fp_wb_arbiter.md
Name: ibex_fp_wb_arbiter

Overview:
- Writeback stage directly upstream of the FP register file's single write port (waddr/wdata/we).
- Merges two producers into that one port, registered: FPU results (buffered, backpressured) and FP loads (FLH, from LSU).
- Keeps a 32-bit pending-write scoreboard so decode can stall on FP RAW hazards.

Parameters:
- DataWidth, 16, FP register width; matches the register file.
- FifoDepth, 2, FPU result buffer entries (>=1).
- StarveLimit, 3, consecutive load wins allowed while the FIFO is full before the FPU is forced through (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- fpu_valid_i  in  1  FPU result valid
- fpu_ready_o  out  1  FIFO can accept
- fpu_waddr_i  in  5  FPU destination register
- fpu_wdata_i  in  DataWidth  FPU result
- ld_valid_i  in  1  FP load data valid
- ld_ready_o  out  1  load accepted this cycle
- ld_waddr_i  in  5  load destination register
- ld_wdata_i  in  DataWidth  load data
- issue_valid_i  in  1  FP-writing instruction issued
- issue_waddr_i  in  5  its destination register
- pending_o  out  32  scoreboard; bit n = write to f<n> outstanding
- fp_waddr_a_o  out  5  register-file write address
- fp_wdata_a_o  out  DataWidth  register-file write data
- fp_we_a_o  out  1  register-file write enable

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: fp_we_a_o=0, fp_waddr_a_o=0, fp_wdata_a_o=0, pending_o=0, FIFO empty, starve counter=0.
- A reset asserted mid-operation discards FIFO contents and any in-flight write.
- FPU input:
  - Handshake when fpu_valid_i && fpu_ready_o; the result is pushed to the FIFO tail.
  - fpu_ready_o = !full. It does not depend on fpu_valid_i and has no combinational path from the load inputs.
- Arbitration, one grant per cycle:
  - If ld_valid_i and !(FIFO full && starve_cnt==StarveLimit), the load wins; ld_ready_o=1.
  - Otherwise, if the FIFO is non-empty, the FIFO head wins and is popped; ld_ready_o=0.
- Starve counter:
  - Increments on a load win while the FIFO is full.
  - Resets to 0 on any FIFO pop, or whenever the FIFO is not full.
- Full + push + pop in the same cycle: fpu_ready_o is low when full, so no push occurs; the pop frees a slot for the next cycle.
- Empty FIFO + push in the same cycle: no bypass. The entry is visible at the head next cycle, so minimum FPU-to-regfile latency is 2 cycles. Load-to-regfile latency is 1 cycle.
- Output register:
  - The granted request is registered into fp_waddr_a_o/fp_wdata_a_o with fp_we_a_o=1.
  - With no grant, fp_we_a_o=0 and address/data hold their previous values.
  - A grant to f0 is consumed but produces fp_we_a_o=0.
- Scoreboard:
  - Set bit issue_waddr_i on issue_valid_i.
  - Clear bit fp_waddr_a_o on the cycle the arbiter registers a grant to that address.
  - Set and clear of the same bit in one cycle: set wins.
  - Bit 0 is never set.
  - Clears only affect bits that are set. Loads use the same clear path; issue covers both FPU ops and FLH.

Optional Feature:
- Macro: IBEX_FP_WB_FWD_EN.
- When defined, adds outputs fwd_valid_o (1), fwd_waddr_o (5) and fwd_wdata_o (DataWidth).
  - These are a combinational copy of this cycle's granted request, before the output register.
  - fwd_valid_o=0 for f0 or no grant.
  - Operand fetch uses them to bypass, saving one cycle.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package ibex_fp_wb_pkg:
  - typedef fp_wb_req_t {logic [4:0] waddr; logic [DataWidth-1:0] wdata;}, with the width taken from the package constant FpDataWidth=16.
  - Constant FpNumRegs=32.
- Sub-module ibex_fp_wb_fifo:
  - Parameterised-depth synchronous FIFO of fp_wb_req_t.
  - Ports: push/pop/full/empty/head.
  - Pointer wrap via count; synchronous active-high reset.

Test Plan:
- Single FPU result f3=0x3C00, no loads -> fp_we_a_o=1, addr 3, data 0x3C00 two cycles after handshake. pending_o[3] set by issue, cleared the same cycle we rises.
- Load f5=0xBC00 and FPU f6=0x4000 in the same cycle, FIFO empty -> cycle+1 writes f5; cycle+2 writes f6.
- FIFO full (2 entries), continuous ld_valid_i -> exactly 3 load grants, then 1 FIFO pop with ld_ready_o=0, then loads resume. fpu_ready_o=0 until the pop.
- Issue f7 while a grant to f7 is registering in the same cycle -> pending_o[7] remains 1.
- FPU write to f0 -> consumed, fp_we_a_o stays 0, pending_o unchanged. Issue to f0 -> pending_o[0] stays 0.
- rst_i asserted with 2 FIFO entries and pending_o=0x00F0 -> next cycle fp_we_a_o=0, pending_o=0, fpu_ready_o=1, and no stale writes after release.
